// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, ALU function codes and the EX-stage record shared by the integer pipeline
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SLT = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR = 3'b100;
  localparam logic [2:0] FUNCT3_SR = 3'b101;
  localparam logic [2:0] FUNCT3_OR = 3'b110;
  localparam logic [2:0] FUNCT3_AND = 3'b111;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0] funct3;
    logic funct7_5;
    logic [4:0] rd;
  } ex_t;
  // The alternate funct7 only means something for subtract and arithmetic shift
  function automatic logic is_legal(input logic [31:0] instr);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    return opc == OPC_LUI ||
      (opc == OPC_OP && (f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && (f3 == FUNCT3_ADD_SUB || f3 == FUNCT3_SR)))) ||
      (opc == OPC_OP_IMM && (f3 == FUNCT3_SLL ? f7 == FUNCT7_BASE :
                             f3 == FUNCT3_SR ? (f7 == FUNCT7_BASE || f7 == FUNCT7_ALT) : 1'b1));
  endfunction
endpackage

// File: rtl/rv32_alu.sv
// rv32_alu: combinational RV32I integer ALU selected by funct3/funct7_5
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  output logic [XLEN-1:0] result_out
);
  logic [4:0] shamt;
  assign shamt = op_2_in[4:0];
  always_comb begin
    result_out = funct3 == FUNCT3_ADD_SUB ? (funct7_5 ? op_1_in - op_2_in : op_1_in + op_2_in) :
                 funct3 == FUNCT3_SLL ? op_1_in << shamt :
                 funct3 == FUNCT3_SLT ? {31'b0, $signed(op_1_in) < $signed(op_2_in)} :
                 funct3 == FUNCT3_SLTU ? {31'b0, op_1_in < op_2_in} :
                 funct3 == FUNCT3_XOR ? op_1_in ^ op_2_in :
                 funct3 == FUNCT3_SR ? (funct7_5 ? $unsigned($signed(op_1_in) >>> shamt) : op_1_in >> shamt) :
                 funct3 == FUNCT3_OR ? op_1_in | op_2_in : op_1_in & op_2_in;
  end
endmodule

// File: rtl/rv32_regfile.sv
// rv32_regfile: 32x32 register file, three combinational reads, one write, x0 never written
module rv32_regfile
  import rv32_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            we_in,
  input  logic [4:0]      waddr_in,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [4:0]      raddr1_in,
  input  logic [4:0]      raddr2_in,
  input  logic [4:0]      raddr3_in,
  output logic [XLEN-1:0] rdata1_out,
  output logic [XLEN-1:0] rdata2_out,
  output logic [XLEN-1:0] rdata3_out
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  always_comb begin
    regs_d = regs_q;
    if (we_in && waddr_in != '0) regs_d[waddr_in] = wdata_in;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign rdata1_out = regs_q[raddr1_in];
  assign rdata2_out = regs_q[raddr2_in];
  assign rdata3_out = regs_q[raddr3_in];
endmodule

// File: rtl/rv32_alu_issue.sv
// rv32_alu_issue: decode/issue front end feeding rv32_alu from a registered EX stage
module rv32_alu_issue
  import rv32_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            instr_valid_in,
  input  logic [31:0]     instr_in,
  output logic            instr_ready_out,
  output logic            alu_valid_out,
  input  logic            alu_ready_in,
  output logic [XLEN-1:0] alu_op_1_out,
  output logic [XLEN-1:0] alu_op_2_out,
  output logic [2:0]      alu_funct3_out,
  output logic            alu_funct7_5_out,
  input  logic [XLEN-1:0] alu_result_in,
  output logic            wb_valid_out,
  output logic [4:0]      wb_rd_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            illegal_out,
  input  logic [4:0]      dbg_raddr_in,
  output logic [XLEN-1:0] dbg_rdata_out
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] rf_rs1, rf_rs2, src1, src2;
  logic accept, complete, wb_en, legal, issue;
  ex_t dec, ex_q, ex_d;
  logic ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d, illegal_q, illegal_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  assign opc = instr_in[6:0];
  assign f3 = instr_in[14:12];
  assign rd = instr_in[11:7];
  assign rs1 = instr_in[19:15];
  assign rs2 = instr_in[24:20];
  assign instr_ready_out = !rst_in && (!ex_valid_q || alu_ready_in);
  assign complete = ex_valid_q && alu_ready_in;
  assign accept = instr_valid_in && instr_ready_out;
  assign wb_en = complete && ex_q.rd != '0;
  assign legal = is_legal(instr_in);
  assign issue = accept && legal;
  rv32_regfile u_rf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .we_in     (wb_en),
    .waddr_in  (ex_q.rd),
    .wdata_in  (alu_result_in),
    .raddr1_in (rs1),
    .raddr2_in (rs2),
    .raddr3_in (dbg_raddr_in),
    .rdata1_out(rf_rs1),
    .rdata2_out(rf_rs2),
    .rdata3_out(dbg_rdata_out)
  );
  // The regfile only sees the completing result after this edge, so bypass it
  assign src1 = wb_en && ex_q.rd == rs1 ? alu_result_in : rf_rs1;
  assign src2 = wb_en && ex_q.rd == rs2 ? alu_result_in : rf_rs2;
  always_comb begin
    dec.op1 = opc == OPC_LUI ? '0 : src1;
    dec.op2 = opc == OPC_LUI ? {instr_in[31:12], 12'b0} :
              opc == OPC_OP ? src2 : {{20{instr_in[31]}}, instr_in[31:20]};
    dec.funct3 = opc == OPC_LUI ? FUNCT3_ADD_SUB : f3;
    dec.funct7_5 = (opc == OPC_OP || (opc == OPC_OP_IMM && f3 == FUNCT3_SR)) ? instr_in[30] : 1'b0;
    dec.rd = rd;
    ex_d = issue ? dec : ex_q;
    ex_valid_d = issue || (ex_valid_q && !alu_ready_in);
    wb_valid_d = wb_en;
    wb_rd_d = wb_en ? ex_q.rd : wb_rd_q;
    wb_data_d = wb_en ? alu_result_in : wb_data_q;
    illegal_d = accept && !legal;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_q <= '0;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      ex_valid_q <= ex_valid_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
    end
  end
  assign alu_valid_out = ex_valid_q;
  assign alu_op_1_out = ex_q.op1;
  assign alu_op_2_out = ex_q.op2;
  assign alu_funct3_out = ex_q.funct3;
  assign alu_funct7_5_out = ex_q.funct7_5;
  assign wb_valid_out = wb_valid_q;
  assign wb_rd_out = wb_rd_q;
  assign wb_data_out = wb_data_q;
  assign illegal_out = illegal_q;
endmodule

// File: tb/tb_rv32_alu_issue.sv
// tb_rv32_alu_issue: directed checks of issue, forwarding, stall, illegal and reset behaviour
module tb_rv32_alu_issue;
  logic clk = 1'b0;
  logic rst, ivalid, iready, avalid, aready, f75, wbv, ill;
  logic [31:0] instr, op1, op2, res, wbd, dbgd;
  logic [2:0] f3;
  logic [4:0] wbr, dbga;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rv32_alu_issue dut (
    .clk_in(clk), .rst_in(rst), .instr_valid_in(ivalid), .instr_in(instr), .instr_ready_out(iready),
    .alu_valid_out(avalid), .alu_ready_in(aready), .alu_op_1_out(op1), .alu_op_2_out(op2),
    .alu_funct3_out(f3), .alu_funct7_5_out(f75), .alu_result_in(res), .wb_valid_out(wbv),
    .wb_rd_out(wbr), .wb_data_out(wbd), .illegal_out(ill), .dbg_raddr_in(dbga), .dbg_rdata_out(dbgd)
  );
  rv32_alu u_alu (.op_1_in(op1), .op_2_in(op2), .funct3(f3), .funct7_5(f75), .result_out(res));
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] fn, input logic [4:0] d, input logic [6:0] opc);
    return {imm, s1, fn, d, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] fn, input logic [4:0] d);
    return {f7, s2, s1, fn, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] d);
    return {imm, d, 7'b0110111};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbga = a;
    #1;
    chk(tag, dbgd, exp);
  endtask
  initial begin
    rst = 1'b1; ivalid = 1'b0; instr = '0; aready = 1'b1; dbga = '0;
    tick; tick;
    chk("rst_alu_valid", {31'b0, avalid}, 0);
    chk("rst_instr_ready", {31'b0, iready}, 0);
    chk("rst_wb_valid", {31'b0, wbv}, 0);
    chk("rst_illegal", {31'b0, ill}, 0);
    chk("rst_op2", op2, 0);
    chk("rst_wb_data", wbd, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, iready}, 1);
    // ADDI x1,x0,5 ; ADDI x2,x0,-3
    ivalid = 1'b1; instr = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    tick;
    chk("addi1_valid", {31'b0, avalid}, 1);
    chk("addi1_op2", op2, 32'd5);
    instr = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
    tick;
    chk("addi1_wb_valid", {31'b0, wbv}, 1);
    chk("addi1_wb_rd", {27'b0, wbr}, 1);
    chk("addi1_wb_data", wbd, 32'd5);
    chk("addi2_op2", op2, 32'hFFFFFFFD);
    chk("addi2_f75", {31'b0, f75}, 0);
    ivalid = 1'b0;
    tick;
    chk("addi2_wb_rd", {27'b0, wbr}, 2);
    chk("addi2_wb_data", wbd, 32'hFFFFFFFD);
    chk("idle_alu_valid", {31'b0, avalid}, 0);
    dbg("dbg_x2", 5'd2, 32'hFFFFFFFD);
    // ADDI x1,x0,7 ; ADD x3,x1,x1 back to back
    ivalid = 1'b1; instr = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011);
    tick;
    instr = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd3);
    tick;
    chk("fwd_op1", op1, 32'd7);
    chk("fwd_op2", op2, 32'd7);
    chk("fwd_wb_x1", wbd, 32'd7);
    ivalid = 1'b0;
    tick;
    chk("add_wb_rd", {27'b0, wbr}, 3);
    chk("add_wb_data", wbd, 32'd14);
    // stall: ADDI x1,x0,10 pending, ADDI x2,x0,3 waiting
    ivalid = 1'b1; instr = enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011);
    tick;
    aready = 1'b0; instr = enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", {31'b0, iready}, 0);
      chk("stall_op2", op2, 32'd10);
      chk("stall_valid", {31'b0, avalid}, 1);
      tick;
      chk("stall_no_wb", {31'b0, wbv}, 0);
    end
    aready = 1'b1;
    tick;
    chk("release_wb_data", wbd, 32'd10);
    chk("release_wb_rd", {27'b0, wbr}, 1);
    chk("release_next_op2", op2, 32'd3);
    instr = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    tick;
    chk("release_wb_once_rd", {27'b0, wbr}, 2);
    chk("sub_f75", {31'b0, f75}, 1);
    chk("sub_op1", op1, 32'd10);
    chk("sub_op2_fwd", op2, 32'd3);
    // LUI x4 ; SRAI x5,x4,1 ; LUI x6
    instr = enc_lui(20'h80000, 5'd4);
    tick;
    chk("sub_wb_data", wbd, 32'd7);
    instr = enc_i(12'h401, 5'd4, 3'b101, 5'd5, 7'b0010011);
    tick;
    chk("lui4_wb_data", wbd, 32'h80000000);
    chk("srai_f75", {31'b0, f75}, 1);
    instr = enc_lui(20'h12345, 5'd6);
    tick;
    chk("srai_wb_data", wbd, 32'hC0000000);
    chk("lui_op1", op1, 0);
    ivalid = 1'b0;
    tick;
    chk("lui_wb_data", wbd, 32'h12345000);
    dbg("dbg_x6", 5'd6, 32'h12345000);
    // illegal encodings
    ivalid = 1'b1; instr = enc_r(7'h20, 5'd1, 5'd1, 3'b111, 5'd8);
    tick;
    chk("ill_op_pulse", {31'b0, ill}, 1);
    chk("ill_op_noissue", {31'b0, avalid}, 0);
    instr = enc_i(12'h401, 5'd1, 3'b001, 5'd8, 7'b0010011);
    tick;
    chk("ill_slli_pulse", {31'b0, ill}, 1);
    chk("ill_slli_noissue", {31'b0, avalid}, 0);
    instr = enc_i(12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011);
    tick;
    chk("ill_load_pulse", {31'b0, ill}, 1);
    chk("ill_load_nowb", {31'b0, wbv}, 0);
    ivalid = 1'b0;
    tick;
    chk("ill_pulse_end", {31'b0, ill}, 0);
    chk("ill_nowb", {31'b0, wbv}, 0);
    dbg("dbg_x8", 5'd8, 0);
    // write to x0
    ivalid = 1'b1; instr = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
    tick;
    ivalid = 1'b0;
    tick;
    chk("x0_nowb", {31'b0, wbv}, 0);
    dbg("dbg_x0", 5'd0, 0);
    // reset while ADDI x7 is stalled in EX
    aready = 1'b0; ivalid = 1'b1; instr = enc_i(12'd42, 5'd0, 3'b000, 5'd7, 7'b0010011);
    tick;
    ivalid = 1'b0;
    tick;
    chk("pre_rst_valid", {31'b0, avalid}, 1);
    chk("pre_rst_op2", op2, 32'd42);
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", {31'b0, avalid}, 0);
    chk("mid_rst_wb", {31'b0, wbv}, 0);
    chk("mid_rst_op2", op2, 0);
    rst = 1'b0; aready = 1'b1;
    tick;
    chk("post_rst_wb", {31'b0, wbv}, 0);
    dbg("post_rst_x7", 5'd7, 0);
    dbg("post_rst_x1", 5'd1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
